// File: rtl/msrv32_mtimer_pkg.sv
// msrv32_mtimer_pkg: register offsets, CTRL layout and helpers shared by the machine timer
package msrv32_mtimer_pkg;
  localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_CTRL        = 3'd4;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] mask);
    logic [31:0] m;
    m = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    return (new_v & m) | (old_v & ~m);
  endfunction
endpackage

// File: rtl/msrv32_mtimer_if.sv
// msrv32_mtimer_if: core data-memory port as seen by the machine timer
interface msrv32_mtimer_if;
  logic [31:0] ms_riscv32_mp_dmaddr_in;
  logic [31:0] ms_riscv32_mp_dmdata_in;
  logic        ms_riscv32_mp_dmwr_req_in;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_in;
  logic        ms_riscv32_mp_dmrd_req_in;
  logic        mtimer_sel_out;
  logic [31:0] mtimer_rdata_out;
  modport master (
    output ms_riscv32_mp_dmaddr_in, ms_riscv32_mp_dmdata_in, ms_riscv32_mp_dmwr_req_in,
           ms_riscv32_mp_dmwr_mask_in, ms_riscv32_mp_dmrd_req_in,
    input  mtimer_sel_out, mtimer_rdata_out
  );
  modport slave (
    input  ms_riscv32_mp_dmaddr_in, ms_riscv32_mp_dmdata_in, ms_riscv32_mp_dmwr_req_in,
           ms_riscv32_mp_dmwr_mask_in, ms_riscv32_mp_dmrd_req_in,
    output mtimer_sel_out, mtimer_rdata_out
  );
endinterface

// File: rtl/msrv32_mtimer_prescaler.sv
// msrv32_mtimer_prescaler: one-cycle tick every DIV+1 enabled cycles; counter holds while disabled
module msrv32_mtimer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  tick_o
);
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && (cnt_q == div_i);
  assign cnt_d  = !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  // divisor counter
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/msrv32_mtimer.sv
// msrv32_mtimer: RISC-V mtime/mtimecmp timer on the data-memory port; prescaler built only with MSRV32_MTIMER_PRESCALER_EN
module msrv32_mtimer
  import msrv32_mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_4000,
  parameter int          PRESCALE_W = 8
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  msrv32_mtimer_if.slave     bus,
  output logic [63:0]        ms_riscv32_mp_rc_out,
  output logic               ms_riscv32_mp_tirq_out
);
  logic        hit, wr, rd, tick;
  logic [2:0]  off;
  logic        wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic [31:0] ctrl_rd, ctrl_new, mlo_new, mhi_new, clo_new, chi_new, rmux;
  logic        en_q, en_d, tirq_q, tirq_d;
  logic        unused_ok;

  assign hit     = bus.ms_riscv32_mp_dmaddr_in[31:5] == BASE_ADDR[31:5];
  assign off     = bus.ms_riscv32_mp_dmaddr_in[4:2];
  assign wr      = hit && bus.ms_riscv32_mp_dmwr_req_in;
  assign rd      = hit && bus.ms_riscv32_mp_dmrd_req_in;
  assign wr_mlo  = wr && off == MTIMER_MTIME_LO;
  assign wr_mhi  = wr && off == MTIMER_MTIME_HI;
  assign wr_clo  = wr && off == MTIMER_MTIMECMP_LO;
  assign wr_chi  = wr && off == MTIMER_MTIMECMP_HI;
  assign wr_ctrl = wr && off == MTIMER_CTRL;

  assign mlo_new  = byte_merge(mtime_q[31:0], bus.ms_riscv32_mp_dmdata_in, bus.ms_riscv32_mp_dmwr_mask_in);
  assign mhi_new  = byte_merge(mtime_q[63:32], bus.ms_riscv32_mp_dmdata_in, bus.ms_riscv32_mp_dmwr_mask_in);
  assign clo_new  = byte_merge(mtimecmp_q[31:0], bus.ms_riscv32_mp_dmdata_in, bus.ms_riscv32_mp_dmwr_mask_in);
  assign chi_new  = byte_merge(mtimecmp_q[63:32], bus.ms_riscv32_mp_dmdata_in, bus.ms_riscv32_mp_dmwr_mask_in);
  assign ctrl_new = byte_merge(ctrl_rd, bus.ms_riscv32_mp_dmdata_in, bus.ms_riscv32_mp_dmwr_mask_in);

`ifdef MSRV32_MTIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] div_q, div_d;
  assign ctrl_rd   = 32'(en_q) | (32'(div_q) << CTRL_DIV_LSB);
  assign div_d     = wr_ctrl ? ctrl_new[CTRL_DIV_LSB +: PRESCALE_W] : div_q;
  assign unused_ok = ^{bus.ms_riscv32_mp_dmaddr_in[1:0], ctrl_new};
  msrv32_mtimer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i  (ms_riscv32_mp_clk_in),
    .rst_i  (ms_riscv32_mp_rst_in),
    .en_i   (en_q),
    .div_i  (div_q),
    .tick_o (tick)
  );
  // divisor field of CTRL
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) div_q <= '0;
    else div_q <= div_d;
  end
`else
  assign ctrl_rd   = 32'(en_q);
  assign tick      = en_q;
  assign unused_ok = ^{bus.ms_riscv32_mp_dmaddr_in[1:0], ctrl_new, PRESCALE_W[0]};
`endif

  // a write to either mtime half owns the whole counter that cycle, so no tick is applied
  always_comb begin
    mtime_d    = (wr_mlo || wr_mhi) ? {wr_mhi ? mhi_new : mtime_q[63:32], wr_mlo ? mlo_new : mtime_q[31:0]}
                                    : tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = {wr_chi ? chi_new : mtimecmp_q[63:32], wr_clo ? clo_new : mtimecmp_q[31:0]};
    shadow_d   = wr_mhi ? mhi_new : (rd && off == MTIMER_MTIME_LO) ? mtime_q[63:32] : shadow_q;
    en_d       = wr_ctrl ? ctrl_new[CTRL_EN_BIT] : en_q;
    rmux       = off == MTIMER_MTIME_LO    ? mtime_q[31:0]     :
                 off == MTIMER_MTIME_HI    ? shadow_q          :
                 off == MTIMER_MTIMECMP_LO ? mtimecmp_q[31:0]  :
                 off == MTIMER_MTIMECMP_HI ? mtimecmp_q[63:32] :
                 off == MTIMER_CTRL        ? ctrl_rd           : '0;
    rdata_d    = rd ? rmux : rdata_q;
    tirq_d     = mtime_q >= mtimecmp_q;
  end

  // timer state, read data and interrupt registers
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      shadow_q   <= '0;
      en_q       <= 1'b1;
      rdata_q    <= '0;
      tirq_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      rdata_q    <= rdata_d;
      tirq_q     <= tirq_d;
    end
  end

  assign bus.mtimer_sel_out   = hit;
  assign bus.mtimer_rdata_out = rdata_q;
  assign ms_riscv32_mp_rc_out   = mtime_q;
  assign ms_riscv32_mp_tirq_out = tirq_q;
endmodule

// File: tb/tb_msrv32_mtimer.sv
// tb_msrv32_mtimer: directed self-checking bench for the machine timer
module tb_msrv32_mtimer;
  import msrv32_mtimer_pkg::*;
  localparam logic [31:0] BASE = 32'h0200_4000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rc;
  logic        tirq;
  int          n_chk = 0;
  int          n_fail = 0;

  msrv32_mtimer_if bus();

  msrv32_mtimer dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_in   (rst),
    .bus                    (bus),
    .ms_riscv32_mp_rc_out   (rc),
    .ms_riscv32_mp_tirq_out (tirq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] m);
    bus.ms_riscv32_mp_dmaddr_in    = BASE | {27'd0, off, 2'b00};
    bus.ms_riscv32_mp_dmdata_in    = d;
    bus.ms_riscv32_mp_dmwr_mask_in = m;
    bus.ms_riscv32_mp_dmwr_req_in  = 1'b1;
    step();
    bus.ms_riscv32_mp_dmwr_req_in  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off);
    bus.ms_riscv32_mp_dmaddr_in   = BASE | {27'd0, off, 2'b00};
    bus.ms_riscv32_mp_dmrd_req_in = 1'b1;
    step();
    bus.ms_riscv32_mp_dmrd_req_in = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_ctrl_all;
`ifdef MSRV32_MTIMER_PRESCALER_EN
    exp_ctrl_all = 32'h0000_FF00;
`else
    exp_ctrl_all = 32'h0000_0000;
`endif
    bus.ms_riscv32_mp_dmaddr_in    = BASE;
    bus.ms_riscv32_mp_dmdata_in    = '0;
    bus.ms_riscv32_mp_dmwr_req_in  = 1'b0;
    bus.ms_riscv32_mp_dmwr_mask_in = '0;
    bus.ms_riscv32_mp_dmrd_req_in  = 1'b0;
    step(2);
    chk("rst_rc", rc, 64'd0);
    chk("rst_tirq", 64'(tirq), 64'd0);
    chk("rst_rdata", 64'(bus.mtimer_rdata_out), 64'd0);
    rst = 1'b0;
    step(10);
    chk("idle_rc", rc, 64'd10);
    chk("idle_tirq", 64'(tirq), 64'd0);
    rd(MTIMER_MTIME_LO);
    chk("rd_lo", 64'(bus.mtimer_rdata_out), 64'd10);
    chk("rd_lo_rc", rc, 64'd11);
    wr(MTIMER_MTIME_LO, 32'd5, 4'hF);
    chk("set5_rc", rc, 64'd5);
    wr(MTIMER_MTIMECMP_LO, 32'd20, 4'hF);
    wr(MTIMER_MTIMECMP_HI, 32'd0, 4'hF);
    chk("cmp_rc", rc, 64'd7);
    chk("cmp_tirq", 64'(tirq), 64'd0);
    step(13);
    chk("pre_irq", 64'(tirq), 64'd0);
    step();
    chk("irq_rise", 64'(tirq), 64'd1);
    chk("irq_rc", rc, 64'd21);
    wr(MTIMER_MTIMECMP_LO, 32'hFFFF_FFFF, 4'hF);
    chk("irq_hold", 64'(tirq), 64'd1);
    step();
    chk("irq_fall", 64'(tirq), 64'd0);
    wr(MTIMER_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    chk("wr_hi_no_inc", rc, 64'hFFFF_FFFF_0000_0017);
    wr(MTIMER_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    chk("wrap_set", rc, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_irq", 64'(tirq), 64'd1);
    step(2);
    chk("wrap_rc", rc, 64'd0);
    chk("wrap_irq_max", 64'(tirq), 64'd1);
    step();
    chk("wrap_irq_fall", 64'(tirq), 64'd0);
    chk("wrap_rc1", rc, 64'd1);
    wr(MTIMER_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd(MTIMER_MTIME_LO);
    chk("snap_lo", 64'(bus.mtimer_rdata_out), 64'hFFFF_FFFF);
    chk("carry_rc", rc, 64'h1_0000_0000);
    rd(MTIMER_MTIME_HI);
    chk("shadow_hi", 64'(bus.mtimer_rdata_out), 64'd0);
    bus.ms_riscv32_mp_dmaddr_in = BASE | 32'h1C;
    #1 chk("sel_hit", 64'(bus.mtimer_sel_out), 64'd1);
    bus.ms_riscv32_mp_dmaddr_in = BASE + 32'h20;
    #1 chk("sel_miss", 64'(bus.mtimer_sel_out), 64'd0);
    step();
    rd(MTIMER_MTIMECMP_LO);
    chk("rd_cmp_lo", 64'(bus.mtimer_rdata_out), 64'hFFFF_FFFF);
    step();
    chk("rdata_hold", 64'(bus.mtimer_rdata_out), 64'hFFFF_FFFF);
    bus.ms_riscv32_mp_dmaddr_in   = BASE + 32'h20;
    bus.ms_riscv32_mp_dmrd_req_in = 1'b1;
    step();
    bus.ms_riscv32_mp_dmrd_req_in = 1'b0;
    chk("miss_hold", 64'(bus.mtimer_rdata_out), 64'hFFFF_FFFF);
    wr(3'd5, 32'h1234_5678, 4'hF);
    rd(3'd5);
    chk("rd_off5", 64'(bus.mtimer_rdata_out), 64'd0);
    wr(MTIMER_MTIMECMP_LO, 32'd0, 4'hF);
    wr(MTIMER_MTIMECMP_LO, 32'h1234_AB56, 4'b0010);
    rd(MTIMER_MTIMECMP_LO);
    chk("byte_wr", 64'(bus.mtimer_rdata_out), 64'h0000_AB00);
    wr(MTIMER_MTIME_LO, 32'h0000_0100, 4'hF);
    chk("tick_collide", rc, 64'h1_0000_0100);
    wr(MTIMER_MTIME_LO, 32'h1234_5678, 4'b0001);
    chk("mtime_byte", rc, 64'h1_0000_0178);
    wr(MTIMER_CTRL, 32'd0, 4'hF);
    chk("dis_edge", rc, 64'h1_0000_0179);
    step(20);
    chk("frozen", rc, 64'h1_0000_0179);
    wr(MTIMER_CTRL, 32'hFFFF_FFFE, 4'hF);
    rd(MTIMER_CTRL);
    chk("ctrl_rsvd", 64'(bus.mtimer_rdata_out), 64'(exp_ctrl_all));
    chk("frozen2", rc, 64'h1_0000_0179);
`ifdef MSRV32_MTIMER_PRESCALER_EN
    wr(MTIMER_CTRL, 32'h0000_0301, 4'hF);
    chk("div_en_edge", rc, 64'h1_0000_0179);
    step(3);
    chk("div_wait", rc, 64'h1_0000_0179);
    step();
    chk("div_tick1", rc, 64'h1_0000_017A);
    step(4);
    chk("div_tick2", rc, 64'h1_0000_017B);
    rd(MTIMER_CTRL);
    chk("ctrl_div", 64'(bus.mtimer_rdata_out), 64'h301);
`else
    wr(MTIMER_CTRL, 32'd1, 4'hF);
    chk("en_edge", rc, 64'h1_0000_0179);
    step();
    chk("en_tick", rc, 64'h1_0000_017A);
    rd(MTIMER_CTRL);
    chk("ctrl_en", 64'(bus.mtimer_rdata_out), 64'h1);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rc", rc, 64'd0);
    chk("mid_rst_tirq", 64'(tirq), 64'd0);
    chk("mid_rst_rdata", 64'(bus.mtimer_rdata_out), 64'd0);
    rd(MTIMER_MTIMECMP_HI);
    chk("rst_cmp_hi", 64'(bus.mtimer_rdata_out), 64'hFFFF_FFFF);
    rd(MTIMER_CTRL);
    chk("rst_ctrl", 64'(bus.mtimer_rdata_out), 64'h1);
    rd(MTIMER_MTIME_HI);
    chk("rst_shadow", 64'(bus.mtimer_rdata_out), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
